// File: rtl/montgomery_mul.sv
`default_nettype none
// ============================================================================
//  Module   : montgomery_mul
//  Brief    : Radix-2 bit-serial Montgomery multiplier, result = A*B*2^-512 mod M,
//             one iteration per clock, start/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module montgomery_mul (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [513:0] in_a,
    input  logic [513:0] in_b,
    input  logic [513:0] in_m,
    output logic [511:0] result,
    output logic         done
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOOP   = 2'd1;
    localparam logic [1:0] c_ST_REDUCE = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;
    localparam logic [8:0] c_LAST_ITER = 9'd511;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [513:0] r_a;
    logic [513:0] r_b;
    logic [513:0] r_m;
    logic [514:0] r_c;
    logic [8:0]   r_cnt;
    logic [511:0] r_result;
    logic         r_done;

    logic [515:0] w_add_b;
    logic [515:0] w_add_m;
    logic [514:0] w_c_nxt;
    logic [515:0] w_diff;
    logic         w_c_ge_m;

    // One Montgomery step: add a_i*B, make even by adding M, halve.
    // The 516-bit intermediates keep C + B + M exact before the shift.
    always_comb begin
        w_add_b = {1'b0, r_c} + (r_a[0] ? {2'b00, r_b} : 516'd0);
        w_add_m = w_add_b + (w_add_b[0] ? {2'b00, r_m} : 516'd0);
        w_c_nxt = 515'(w_add_m >> 1);
    end

    // Final conditional subtraction; sign bit of the widened difference
    // tells whether C >= M.
    always_comb begin
        w_diff   = {1'b0, r_c} - {2'b00, r_m};
        w_c_ge_m = ~w_diff[515];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (start) w_state_nxt = c_ST_LOOP;
            c_ST_LOOP:   if (r_cnt == c_LAST_ITER) w_state_nxt = c_ST_REDUCE;
            c_ST_REDUCE: w_state_nxt = c_ST_DONE;
            c_ST_DONE:   w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_c      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // done is asserted exactly while the FSM sits in DONE
            r_done  <= (r_state == c_ST_REDUCE);
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_m   <= in_m;
                        r_c   <= '0;
                        r_cnt <= '0;
                    end
                end
                c_ST_LOOP: begin
                    r_c   <= w_c_nxt;
                    r_a   <= r_a >> 1;
                    r_cnt <= r_cnt + 9'd1;
                end
                c_ST_REDUCE: begin
                    r_result <= w_c_ge_m ? 512'(w_diff) : 512'(r_c);
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_montgomery_mul.sv
`default_nettype none
// ============================================================================
//  Module   : tb_montgomery_mul
//  Brief    : Self-checking bench for montgomery_mul against a modular-arithmetic
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_montgomery_mul;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [513:0] in_a;
    logic [513:0] in_b;
    logic [513:0] in_m;
    logic [511:0] result;
    logic         done;

    montgomery_mul dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in_a   (in_a),
        .in_b   (in_b),
        .in_m   (in_m),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    int n_total  = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int ops      = 0;
    logic [511:0] last_result;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    function automatic logic [513:0] rand512();
        logic [513:0] r = '0;
        for (int i = 0; i < 16; i++) r = {r[481:0], 32'($urandom)};
        return r;
    endfunction

    function automatic logic [513:0] rand_modulus();
        logic [513:0] m = rand512();
        if ($urandom_range(0, 1) == 1) m = m >> $urandom_range(1, 480);
        m[0] = 1'b1;
        if (m < 514'd3) m = 514'd3;
        return m;
    endfunction

    // Reference: reduce A*B mod M, then multiply by the inverse of 2 mod M 512 times.
    function automatic logic [511:0] model(input logic [513:0] a, b, m);
        logic [1055:0] p;
        logic [1055:0] mm;
        mm = 1056'(m);
        p  = (1056'(a) * 1056'(b)) % mm;
        for (int i = 0; i < 512; i++) p = p[0] ? (p + mm) >> 1 : p >> 1;
        return 512'(p);
    endfunction

    function automatic logic [513:0] pow2_512_mod(input logic [513:0] m);
        logic [1055:0] t;
        t = 1056'(1) << 512;
        return 514'(t % 1056'(m));
    endfunction

    // Entered at a negedge of a DONE cycle (or idle); leaves at the negedge of the DONE cycle.
    task automatic run_op(input string tag, input logic [513:0] a, b, m,
                          input logic [511:0] exp, input bit poke, input bit hold);
        int cyc;
        @(negedge clk);
        check({tag, "_idle_done"}, 512'(done), 512'(0));
        check({tag, "_hold"}, result, last_result);
        in_a = a; in_b = b; in_m = m; start = 1'b1;
        @(negedge clk);
        ops++;
        start = 1'b0;
        in_a = rand512(); in_b = rand512(); in_m = rand_modulus();
        cyc = 0;
        while (!done && cyc < 600) begin
            start = poke && (cyc == 200);
            @(negedge clk);
            cyc++;
        end
        start = hold;
        check({tag, "_latency"}, 512'(cyc + 1), 512'(514));
        check({tag, "_result"}, result, exp);
        last_result = exp;
    endtask

    initial begin
        logic [513:0] a, b, m;
        logic [511:0] ia, ib;
        int d0;

        reset = 1'b1; start = 1'b0; in_a = '0; in_b = '0; in_m = '0;
        last_result = '0;
        repeat (3) begin
            @(negedge clk);
            check("rst_done", 512'(done), 512'(0));
            check("rst_result", result, 512'(0));
        end
        reset = 1'b0;
        repeat (600) @(negedge clk);
        check("rst_no_done", 512'(done_cnt), 512'(0));
        check("rst_result_idle", result, 512'(0));

        ia = 512'(64'd422335678912344321);
        ib = 512'(64'd567897654328765678);
        run_op("identity", 514'(ia), 514'(ib), {2'b00, {512{1'b1}}}, ia * ib, 0, 0);

        run_op("m5", 514'd3, 514'd4, 514'd5, 512'd2, 0, 1);
        run_op("m3", 514'd2, 514'd2, 514'd3, 512'd1, 0, 0);

        m = rand_modulus();
        b = rand512() % m;
        run_op("a_zero", 514'd0, b, m, 512'd0, 0, 0);

        m = rand_modulus();
        b = rand512() % m;
        run_op("a_one", pow2_512_mod(m), b, m, 512'(b), 0, 0);

        for (int i = 0; i < 30; i++) begin
            m = rand_modulus();
            a = rand512() % m;
            b = rand512() % m;
            run_op($sformatf("rand%0d", i), a, b, m, model(a, b, m), 1, 0);
        end

        // Abort an operation 200 cycles into the loop.
        @(negedge clk);
        in_a = 514'd3; in_b = 514'd4; in_m = 514'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_done", 512'(done), 512'(0));
        check("mid_rst_result", result, 512'(0));
        d0 = done_cnt;
        repeat (600) @(negedge clk);
        check("mid_rst_no_done", 512'(done_cnt), 512'(d0));
        last_result = '0;
        run_op("after_rst", 514'd3, 514'd4, 514'd5, 512'd2, 0, 0);

        @(negedge clk);
        check("done_pulses", 512'(done_cnt), 512'(ops));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
